// File: rtl/mul_arbiter.sv
// Round-robin arbiter that feeds a single shared shift-add multiplier for the
// M-extension multiply ops and returns results on a backpressured data bus.
module mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int ROB_W = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][31:0]          req_a,
    input  logic [N_REQ-1:0][31:0]          req_b,
    input  logic [N_REQ-1:0][2:0]           req_funct3,
    input  logic [N_REQ-1:0][ROB_W-1:0]     req_rob_id,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            mul_start,
    output logic [1:0]                      mul_type,
    output logic [31:0]                     mul_a,
    output logic [31:0]                     mul_b,
    input  logic                            mul_done,
    input  logic [63:0]                     mul_p,
    output logic                            resp_valid,
    output logic [ROB_W-1:0]                resp_rob_id,
    output logic [31:0]                     resp_data,
    input  logic                            resp_ready,
    input  logic                            flush,
    output logic                            busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] { IDLE, WAIT, RESP, DRAIN } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [2:0]         r_funct3;
    logic [ROB_W-1:0]   r_rob_id;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [1:0]         r_mul_type;
    logic [31:0]        r_resp_data;

    logic               w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_scan_idx;
    logic [PTR_W-1:0]   w_next_ptr;

    function automatic logic [1:0] decode_type(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b10:   return 2'b10;
            2'b11:   return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // Scan offsets from farthest to nearest so the first eligible requester
    // at or after r_rr_ptr is the one left standing; funct3 1xx is never eligible.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        if (rst && r_state == IDLE && !flush) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_scan_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
                if (req_valid[w_scan_idx] && !req_funct3[w_scan_idx][2]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = w_scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_next_ptr  = PTR_W'((int'(w_grant_idx) + 1) % N_REQ);
    assign mul_start   = w_grant;
    assign mul_a       = w_grant ? req_a[w_grant_idx] : r_mul_a;
    assign mul_b       = w_grant ? req_b[w_grant_idx] : r_mul_b;
    assign mul_type    = w_grant ? decode_type(req_funct3[w_grant_idx][1:0]) : r_mul_type;
    assign resp_valid  = (r_state == RESP);
    assign busy        = (r_state != IDLE);
    assign resp_data   = r_resp_data;
    assign resp_rob_id = r_rob_id;

    // A product arriving together with a flush is dropped rather than presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_funct3    <= '0;
            r_rob_id    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_type  <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state    <= WAIT;
                        r_mul_a    <= req_a[w_grant_idx];
                        r_mul_b    <= req_b[w_grant_idx];
                        r_mul_type <= decode_type(req_funct3[w_grant_idx][1:0]);
                        r_funct3   <= req_funct3[w_grant_idx];
                        r_rob_id   <= req_rob_id[w_grant_idx];
                        r_rr_ptr   <= w_next_ptr;
                    end
                end
                WAIT: begin
                    if (mul_done) begin
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_state     <= RESP;
                            r_resp_data <= (r_funct3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                RESP: begin
                    if (flush || resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mul_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic,
// a behavioural multiplier, a transaction-level reference model and a response scoreboard.
module tb_mul_arbiter;

   localparam int N  = 4;
   localparam int RW = 5;

   typedef enum { P_IDLE, P_WAIT, P_RESP, P_DRAIN } phase_t;
   typedef struct { logic [RW-1:0] rob; logic [31:0] data; } resp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [N-1:0]         req_valid = '0;
   logic [N-1:0][31:0]   req_a = '0;
   logic [N-1:0][31:0]   req_b = '0;
   logic [N-1:0][2:0]    req_funct3 = '0;
   logic [N-1:0][RW-1:0] req_rob_id = '0;
   logic [N-1:0]         req_ready;
   logic                 mul_start;
   logic [1:0]           mul_type;
   logic [31:0]          mul_a;
   logic [31:0]          mul_b;
   logic                 mul_done = 1'b0;
   logic [63:0]          mul_p = '0;
   logic                 resp_valid;
   logic [RW-1:0]        resp_rob_id;
   logic [31:0]          resp_data;
   logic                 resp_ready = 1'b0;
   logic                 flush = 1'b0;
   logic                 busy;

   int      checks = 0;
   int      failures = 0;
   phase_t  phase = P_IDLE;
   int      ptr = 0;
   resp_t   expQ[$];
   int      grantLog[$];
   int      fixedLat = 0;
   bit      spurious = 1'b0;
   int      mulLeft = 0;
   logic [31:0] opA, opB;
   logic [1:0]  opT;
   logic [1:0]  grantType;

   mul_arbiter #(.N_REQ(N), .ROB_W(RW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_funct3(req_funct3), .req_rob_id(req_rob_id), .req_ready(req_ready),
      .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_p(mul_p),
      .resp_valid(resp_valid), .resp_rob_id(resp_rob_id), .resp_data(resp_data),
      .resp_ready(resp_ready), .flush(flush), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Architectural result of each M-extension multiply, from two's-complement arithmetic.
   function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] full;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (f3)
         3'd0, 3'd1: full = 64'(sa * sb);
         3'd2:       full = 64'(sa * ub);
         default:    full = {32'h0, a} * {32'h0, b};
      endcase
      return (f3 == 3'd0) ? full[31:0] : full[63:32];
   endfunction

   function automatic logic [1:0] expType(input logic [2:0] f3);
      if (f3 == 3'd2) return 2'b10;
      if (f3 == 3'd3) return 2'b00;
      return 2'b01;
   endfunction

   function automatic int pickRequester(input int p, input logic [N-1:0] v, input logic [N-1:0][2:0] f);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N] && !f[(p + k) % N][2]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [63:0] mulProduct(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
      case (t)
         2'b00:   return {32'h0, a} * {32'h0, b};
         2'b01:   return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
         2'b10:   return 64'($signed({{32{a[31]}}, a}) * $signed({32'h0, b}));
         default: return 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
   endfunction

   // Behavioural shared multiplier: captures a start, answers after 1-4 cycles.
   always begin
      @(negedge clk);
      if (!rst) begin
         mulLeft = 0;
      end else if (mul_start) begin
         opA = mul_a;
         opB = mul_b;
         opT = mul_type;
         mulLeft = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
      end
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      if (!rst) begin
         mulLeft = 0;
      end else if (mulLeft > 0) begin
         mulLeft--;
         if (mulLeft == 0) begin
            mul_done = 1'b1;
            mul_p = mulProduct(opA, opB, opT);
         end
      end else if (spurious && (phase == P_IDLE || phase == P_RESP) && $urandom_range(0, 19) == 0) begin
         mul_done = 1'b1;
         mul_p = {$urandom(), $urandom()};
      end
   end

   // Reference model: tracks the life of the single outstanding multiply and
   // checks grant, start, operand and status outputs each cycle.
   always @(negedge clk) begin : model
      int g;
      logic [N-1:0] expReady;
      if (!rst) begin
         phase = P_IDLE;
         ptr = 0;
         expQ.delete();
      end else begin
         g = (phase == P_IDLE && !flush) ? pickRequester(ptr, req_valid, req_funct3) : -1;
         expReady = '0;
         if (g >= 0) expReady[g] = 1'b1;
         checkOutput("busy", 64'(busy), 64'(phase != P_IDLE));
         checkOutput("resp_valid", 64'(resp_valid), 64'(phase == P_RESP));
         checkOutput("req_ready", 64'(req_ready), 64'(expReady));
         checkOutput("mul_start", 64'(mul_start), 64'(g >= 0));
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               grantLog.push_back(i);
               break;
            end
         end
         if (g >= 0) begin
            checkOutput("mul_a", 64'(mul_a), 64'(req_a[g]));
            checkOutput("mul_b", 64'(mul_b), 64'(req_b[g]));
            checkOutput("mul_type", 64'(mul_type), 64'(expType(req_funct3[g])));
            expQ.push_back('{rob: req_rob_id[g], data: refResult(req_funct3[g], req_a[g], req_b[g])});
            ptr = (g + 1) % N;
            phase = P_WAIT;
         end else begin
            case (phase)
               P_WAIT: begin
                  if (mul_done) phase = flush ? P_IDLE : P_RESP;
                  else if (flush) phase = P_DRAIN;
                  if (flush) expQ.delete();
               end
               P_DRAIN: if (mul_done) phase = P_IDLE;
               P_RESP:  if (flush || resp_ready) phase = P_IDLE;
               default: ;
            endcase
         end
      end
   end

   // Scoreboard monitor: every presented response must match the oldest expected one.
   always @(negedge clk) begin
      if (rst && resp_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_resp: got rob %0h data %0h, expected no response", resp_rob_id, resp_data);
         end else begin
            checkOutput("resp_rob_id", 64'(resp_rob_id), 64'(expQ[0].rob));
            checkOutput("resp_data", 64'(resp_data), 64'(expQ[0].data));
            if (resp_ready || flush) void'(expQ.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic [RW-1:0] rob);
      req_a[i] = a;
      req_b[i] = b;
      req_funct3[i] = f3;
      req_rob_id[i] = rob;
      req_valid[i] = 1'b1;
   endtask

   task automatic waitGrant(input int i, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            seen = 1'b1;
            grantType = mul_type;
         end
      end
      checkOutput({name, "_grant"}, 64'(seen), 64'd1);
      tick();
      req_valid[i] = 1'b0;
   endtask

   task automatic waitResp(input string name, output int lat);
      bit seen = 1'b0;
      lat = 0;
      while (lat < 50 && !seen) begin
         @(negedge clk);
         lat++;
         seen = resp_valid;
      end
      checkOutput({name, "_resp_seen"}, 64'(seen), 64'd1);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 4))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int lat;
      int expOrder[5];
      bit done;
      expOrder = '{0, 1, 2, 3, 0};

      // Reset state with requests pending must not leak a grant.
      for (int i = 0; i < N; i++) applyStimulus(i, 32'h11, 32'h22, 3'd0, RW'(i));
      tick();
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_mul_start", 64'(mul_start), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
      checkOutput("rst_resp_data", 64'(resp_data), 64'd0);
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();

      // Single MUL with known latency.
      resp_ready = 1'b1;
      fixedLat = 3;
      applyStimulus(0, 32'd7, 32'hFFFF_FFFD, 3'd0, RW'(4));
      waitGrant(0, "single");
      checkOutput("single_type", 64'(grantType), 64'd1);
      waitResp("single", lat);
      checkOutput("single_latency", 64'(lat), 64'd4);
      checkOutput("single_data", 64'(resp_data), 64'hFFFF_FFEB);
      checkOutput("single_rob", 64'(resp_rob_id), 64'd4);
      tick();

      // MULHU of the largest operands.
      fixedLat = 0;
      applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, RW'(9));
      waitGrant(1, "mulhu");
      checkOutput("mulhu_type", 64'(grantType), 64'd0);
      waitResp("mulhu", lat);
      checkOutput("mulhu_data", 64'(resp_data), 64'hFFFF_FFFE);
      tick();

      // Backpressure: result held while another request waits.
      resp_ready = 1'b0;
      applyStimulus(2, 32'd12345, 32'd678, 3'd0, RW'(17));
      waitGrant(2, "bp");
      applyStimulus(3, 32'd3, 32'd5, 3'd1, RW'(18));
      waitResp("bp", lat);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkOutput("bp_hold_valid", 64'(resp_valid), 64'd1);
         checkOutput("bp_hold_data", 64'(resp_data), 64'd8369910);
         checkOutput("bp_hold_rob", 64'(resp_rob_id), 64'd17);
         checkOutput("bp_hold_no_grant", 64'(req_ready), 64'd0);
      end
      tick();
      resp_ready = 1'b1;
      waitGrant(3, "bp_next");
      waitResp("bp_next", lat);
      tick();

      // Flush while waiting on the multiplier.
      fixedLat = 4;
      applyStimulus(0, 32'd5, 32'd6, 3'd0, RW'(3));
      waitGrant(0, "flush");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_drain_busy", 64'(busy), 64'd1);
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         done = !busy;
      end
      checkOutput("flush_back_idle", 64'(done), 64'd1);
      tick();
      applyStimulus(1, 32'd2, 32'd3, 3'd0, RW'(11));
      waitGrant(1, "after_flush");
      waitResp("after_flush", lat);
      checkOutput("after_flush_rob", 64'(resp_rob_id), 64'd11);
      checkOutput("after_flush_data", 64'(resp_data), 64'd6);
      tick();

      // Asynchronous reset mid-multiply.
      applyStimulus(2, 32'd9, 32'd9, 3'd0, RW'(5));
      waitGrant(2, "areset");
      applyStimulus(3, 32'd1, 32'd1, 3'd0, RW'(6));
      #1;
      rst = 1'b0;
      #1;
      checkOutput("areset_busy", 64'(busy), 64'd0);
      checkOutput("areset_resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("areset_req_ready", 64'(req_ready), 64'd0);
      checkOutput("areset_mul_a", 64'(mul_a), 64'd0);
      tick();
      req_valid = '0;
      tick();
      rst = 1'b1;
      tick();

      // Fairness: all requesters continuously valid, pointer restarts at 0.
      fixedLat = 0;
      grantLog.delete();
      for (int i = 0; i < N; i++) applyStimulus(i, pickOperand(), pickOperand(), 3'($urandom_range(0, 3)), RW'(i + 20));
      for (int n = 0; n < 200 && grantLog.size() < 5; n++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i < grantLog.size()) checkOutput("fair_order", 64'(grantLog[i]), 64'(expOrder[i]));
         else checkOutput("fair_order_count", 64'(grantLog.size()), 64'd5);
      end
      tick();
      req_valid = '0;

      // Randomized traffic with flushes, backpressure and stray mul_done pulses.
      spurious = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_a[i] = pickOperand();
               req_b[i] = pickOperand();
               req_funct3[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
               req_rob_id[i] = RW'($urandom());
            end
         end
         flush = ($urandom_range(0, 19) == 0);
         resp_ready = ($urandom_range(0, 9) < 7);
      end
      tick();
      req_valid = '0;
      flush = 1'b0;
      resp_ready = 1'b1;
      spurious = 1'b0;
      for (int n = 0; n < 20; n++) tick();
      checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
      checkOutput("final_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesting execution units.
REQ-002 Parameter ROB_W, default 5: width of the ROB index.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port req_valid, input, N_REQ: requester i holds a ready multiply (both operands valid).
REQ-006 Port req_a, req_b, input, N_REQ x 32: operands rs1_v and rs2_v per requester.
REQ-007 Port req_funct3, input, N_REQ x 3: M-extension funct3 per requester.
REQ-008 Port req_rob_id, input, N_REQ x ROB_W: destination ROB index per requester.
REQ-009 Port req_ready, output, N_REQ: one-hot; requester i's request is accepted this cycle.
REQ-010 Port mul_start, output, 1: single-cycle start pulse to the shared shift-add multiplier.
REQ-011 Port mul_type, output, 2: 00 unsigned x unsigned; 01 signed x signed; 10 signed x unsigned.
REQ-012 Port mul_a, mul_b, output, 32 each: multiplier operands.
REQ-013 Port mul_done, input, 1: multiplier result valid.
REQ-014 Port mul_p, input, 64: multiplier product.
REQ-015 Port resp_valid, output, 1: a result is presented on the data bus.
REQ-016 Port resp_rob_id, output, ROB_W: ROB index of the presented result.
REQ-017 Port resp_data, output, 32: 32-bit result.
REQ-018 Port resp_ready, input, 1: the data bus accepts the result this cycle.
REQ-019 Port flush, input, 1: branch mispredict; discard all in-flight work.
REQ-020 Port busy, output, 1: high in any state except IDLE.

Function
REQ-021 The block SHALL implement the FSM states IDLE, WAIT, RESP and DRAIN.
REQ-022 In IDLE with any req_valid set and flush low, the block SHALL grant exactly one requester: the first set bit at or after rr_ptr, searching circularly.
REQ-023 In the grant cycle, the block SHALL assert req_ready[g] and mul_start, drive mul_a/mul_b from requester g, and latch rob_id, funct3 and g internally.
REQ-024 The block SHALL move from IDLE to WAIT on the next edge after a grant and set rr_ptr to (g+1) mod N_REQ.
REQ-025 req_ready SHALL be zero in every cycle except a grant cycle; there SHALL be at most one outstanding multiply.
REQ-026 mul_type SHALL decode from funct3: 000 and 001 give 01; 010 gives 10; 011 gives 00.
REQ-027 funct3 values 1xx SHALL never be granted; those requests are ignored.
REQ-028 mul_a, mul_b and mul_type SHALL hold their latched values through WAIT.
REQ-029 In WAIT, mul_done SHALL latch the result on the same edge and move to RESP.
REQ-030 The latched result SHALL be mul_p[31:0] for funct3 000 and mul_p[63:32] otherwise.
REQ-031 In RESP, the block SHALL assert resp_valid with the latched rob_id and data, and hold them stable until resp_ready.
REQ-032 In RESP with resp_ready high, the block SHALL return to IDLE; a new grant is possible at the earliest on the following cycle.
REQ-033 Latency from grant to resp_valid SHALL be (multiplier cycles + 1).
REQ-034 flush in IDLE SHALL suppress the grant in that cycle.
REQ-035 flush in WAIT SHALL move to DRAIN, or straight to IDLE if mul_done is high in the same cycle.
REQ-036 In DRAIN, the block SHALL ignore requests and move to IDLE on mul_done, discarding the product.
REQ-037 flush in RESP SHALL drop resp_valid on the next edge and move to IDLE, even if resp_ready is high.
REQ-038 flush in DRAIN SHALL have no additional effect.
REQ-039 mul_done outside WAIT and DRAIN SHALL be ignored.
REQ-040 With a single requester continuously valid, the block SHALL grant it on every IDLE visit (no starvation of a lone requester).

Reset
REQ-041 Asserting rst low SHALL asynchronously force state IDLE and rr_ptr 0.
REQ-042 Asserting rst low SHALL force req_ready, mul_start, resp_valid and busy to 0, and mul_a, mul_b, resp_data and resp_rob_id to 0.
REQ-043 Release of rst SHALL take effect synchronously.
REQ-044 Reset mid-multiply SHALL discard the result; the multiplier is reset by the same rst.

Verification
REQ-045 Single mul: req 0, a=7, b=-3, funct3 000, rob 4 -> one mul_start and mul_type 01 -> resp_data 0xFFFFFFEB, rob 4.
REQ-046 mulhu: a=b=0xFFFFFFFF, funct3 011 -> mul_type 00 -> resp_data 0xFFFFFFFE.
REQ-047 Fairness: all 4 requesters valid continuously -> grants in order 0,1,2,3,0; each req_ready is a one-cycle pulse.
REQ-048 Backpressure: resp_ready held low 5 cycles in RESP -> resp_valid, data and rob_id stable for the whole hold; no new grant until accepted.
REQ-049 Flush in WAIT: -> state DRAIN; the product is discarded on mul_done; resp_valid never asserts; the next request is granted after IDLE.
REQ-050 Async reset in WAIT: rst low between clock edges -> busy=0 and resp_valid=0 immediately; rr_ptr=0 after release.
